// File: rtl/axi_read_arbiter_rr.sv
// axi_read_arbiter_rr
// AXI read-channel arbiter. Grants one of NUM_MASTERS masters access to one of
// NUM_SLAVES slaves for a complete read burst. The selected master's address is
// decoded through a base/mask table. Beats are counted against the latched ARLEN.
// A master that currently owns the write arbiter (wr_block) cannot win a new read grant.
//
// Build option:
//   READ_ARB_RR_EN  defined   -> round-robin arbitration. The search starts at a
//                                pointer that advances past each completed burst.
//                   undefined -> fixed priority. The lowest eligible index wins.
//
// Ports:
//   ACLK, ARESETn      clock, synchronous active-low reset
//   ARVALID[NM]        per-master AR request
//   ARADDR[NM*ADDR_W]  per-master address, master i at [i*ADDR_W +: ADDR_W]
//   ARLEN[NM*LEN_W]    per-master burst length minus one
//   ARREADY            AR ready from the selected slave
//   RVALID/RREADY/RLAST  R channel of the selected path
//   wr_block[NM]       master owns the write side; ineligible for a new grant
//   grant_valid        a grant is held
//   grant_mst          granted master index
//   grant_slv          decoded slave index (NUM_SLAVES = default/decode-error slave)
//   ar_phase           AR handshake still pending for the current grant
//   decerr             the held grant targets the default slave
//   len_err            one-cycle pulse when RLAST disagrees with the beat count
module axi_read_arbiter_rr #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 8,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {
        32'h0003_0000, 32'h0010_0000, 32'h2000_0000, 32'h1001_0000,
        32'h1000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_MASTERS-1:0]        ARVALID,
    input  logic [NUM_MASTERS*ADDR_W-1:0] ARADDR,
    input  logic [NUM_MASTERS*LEN_W-1:0]  ARLEN,
    input  logic                          ARREADY,
    input  logic                          RVALID,
    input  logic                          RREADY,
    input  logic                          RLAST,
    input  logic [NUM_MASTERS-1:0]        wr_block,
    output logic                          grant_valid,
    output logic [$clog2(NUM_MASTERS)-1:0]  grant_mst,
    output logic [$clog2(NUM_SLAVES+1)-1:0] grant_slv,
    output logic                          ar_phase,
    output logic                          decerr,
    output logic                          len_err
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int SW = $clog2(NUM_SLAVES+1);
    localparam int CW = LEN_W + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_nxt;

    logic [NUM_MASTERS-1:0] elig;
    logic [MW-1:0]          sel;
    logic [ADDR_W-1:0]      sel_addr;
    logic [NUM_SLAVES-1:0]  hit;
    logic [SW-1:0]          dec_slv;
    logic [LEN_W-1:0]       len_q, len_nxt;
    logic [CW-1:0]          cnt_q, cnt_nxt;
    logic                   beat, cnt_at_len;
    logic                   grant_valid_nxt, ar_phase_nxt, decerr_nxt, len_err_nxt;
    logic [MW-1:0]          grant_mst_nxt;
    logic [SW-1:0]          grant_slv_nxt;

    assign elig = ARVALID & ~wr_block;

`ifdef READ_ARB_RR_EN
    logic [MW-1:0] rr_ptr, rr_ptr_nxt;

    function automatic logic [MW-1:0] wrap_add(input logic [MW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return MW'(s);
    endfunction

    // Walk from the farthest offset down so the offset closest to the pointer wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_MASTERS-1; i >= 0; i--)
            if (elig[wrap_add(rr_ptr, i)]) sel = wrap_add(rr_ptr, i);
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_MASTERS-1; i >= 0; i--)
            if (elig[i]) sel = MW'(i);
    end
`endif

    assign sel_addr = ARADDR[int'(sel)*ADDR_W +: ADDR_W];

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_dec
        assign hit[s] = (sel_addr & SLV_MASK[s*ADDR_W +: ADDR_W]) == SLV_BASE[s*ADDR_W +: ADDR_W];
    end

    // Lowest matching slave wins; no match falls through to the default slave.
    always_comb begin
        dec_slv = SW'(NUM_SLAVES);
        for (int s = NUM_SLAVES-1; s >= 0; s--)
            if (hit[s]) dec_slv = SW'(s);
    end

    assign beat       = RVALID && RREADY;
    assign cnt_at_len = (cnt_q == {1'b0, len_q});

    // State register together with the registered outputs and burst context.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_mst   <= '0;
            grant_slv   <= SW'(NUM_SLAVES);
            ar_phase    <= 1'b0;
            decerr      <= 1'b0;
            len_err     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
`ifdef READ_ARB_RR_EN
            rr_ptr      <= '0;
`endif
        end else begin
            state       <= state_nxt;
            grant_valid <= grant_valid_nxt;
            grant_mst   <= grant_mst_nxt;
            grant_slv   <= grant_slv_nxt;
            ar_phase    <= ar_phase_nxt;
            decerr      <= decerr_nxt;
            len_err     <= len_err_nxt;
            len_q       <= len_nxt;
            cnt_q       <= cnt_nxt;
`ifdef READ_ARB_RR_EN
            rr_ptr      <= rr_ptr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|elig)                         state_nxt = ADDR;
            ADDR:    if (ARVALID[grant_mst] && ARREADY) state_nxt = DATA;
            DATA:    if (beat && RLAST)                 state_nxt = IDLE;
            default:                                    state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs; everything holds unless an event moves it.
    always_comb begin
        grant_valid_nxt = grant_valid;
        grant_mst_nxt   = grant_mst;
        grant_slv_nxt   = grant_slv;
        ar_phase_nxt    = ar_phase;
        decerr_nxt      = decerr;
        len_err_nxt     = 1'b0;
        len_nxt         = len_q;
        cnt_nxt         = cnt_q;
`ifdef READ_ARB_RR_EN
        rr_ptr_nxt      = rr_ptr;
`endif
        case (state)
            IDLE: if (|elig) begin
                grant_valid_nxt = 1'b1;
                ar_phase_nxt    = 1'b1;
                grant_mst_nxt   = sel;
                grant_slv_nxt   = dec_slv;
                decerr_nxt      = (dec_slv == SW'(NUM_SLAVES));
                len_nxt         = ARLEN[int'(sel)*LEN_W +: LEN_W];
            end
            ADDR: if (ARVALID[grant_mst] && ARREADY) begin
                ar_phase_nxt = 1'b0;
                cnt_nxt      = '0;
            end
            DATA: if (beat) begin
                // Saturate rather than wrap so an overlong burst keeps flagging.
                if (!(&cnt_q)) cnt_nxt = cnt_q + 1'b1;
                // Early RLAST and missing RLAST at the expected beat both flag.
                len_err_nxt = RLAST ? !cnt_at_len : cnt_at_len;
                if (RLAST) begin
                    grant_valid_nxt = 1'b0;
                    decerr_nxt      = 1'b0;
`ifdef READ_ARB_RR_EN
                    rr_ptr_nxt      = wrap_add(grant_mst, 1);
`endif
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
module tb_axi_read_arbiter_rr;
    localparam int NM = 3;
    localparam int NS = 8;
    localparam int AW = 32;
    localparam int LW = 4;

    logic           ACLK = 1'b0;
    logic           ARESETn = 1'b0;
    logic [NM-1:0]  ARVALID = '0;
    logic [NM*AW-1:0] ARADDR = '0;
    logic [NM*LW-1:0] ARLEN = '0;
    logic           ARREADY = 1'b0, RVALID = 1'b0, RREADY = 1'b0, RLAST = 1'b0;
    logic [NM-1:0]  wr_block = '0;
    logic           grant_valid, ar_phase, decerr, len_err;
    logic [1:0]     grant_mst;
    logic [3:0]     grant_slv;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr     = 0;   // reference round-robin start point

    bit [31:0] map_base [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1000_0000,
                                 32'h1001_0000, 32'h2000_0000, 32'h0010_0000, 32'h0003_0000};
    bit [31:0] map_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                 32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    axi_read_arbiter_rr dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID(ARVALID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARREADY(ARREADY), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
        .wr_block(wr_block), .grant_valid(grant_valid), .grant_mst(grant_mst),
        .grant_slv(grant_slv), .ar_phase(ar_phase), .decerr(decerr), .len_err(len_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input bit [31:0] a);
        for (int s = 0; s < NS; s++)
            if ((a & map_mask[s]) == map_base[s]) return s;
        return NS;
    endfunction

    function automatic int pick(input bit [NM-1:0] elig);
        for (int i = 0; i < NM; i++) begin
`ifdef READ_ARB_RR_EN
            int idx = (ptr + i) % NM;
`else
            int idx = i;
`endif
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ".gv"},   32'(grant_valid), 32'd0);
        check({tag, ".mst"},  32'(grant_mst),   32'd0);
        check({tag, ".slv"},  32'(grant_slv),   32'(NS));
        check({tag, ".arp"},  32'(ar_phase),    32'd0);
        check({tag, ".dec"},  32'(decerr),      32'd0);
        check({tag, ".lerr"}, 32'(len_err),     32'd0);
    endtask

    task automatic reset_dut();
        ARESETn = 1'b0; ARVALID = '0; wr_block = '0; ARREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
        step();
        check_reset("rst");
        ARESETn = 1'b1;
        ptr = 0;
    endtask

    // One full burst: request, AR handshake after a random delay, nb beats with
    // random stalls, RLAST on beat nb. rst_at > 0 pulls reset after that beat.
    task automatic burst(input string tag, input bit [NM-1:0] av, input bit [NM-1:0] wb,
                         input bit [31:0] a0, input bit [31:0] a1, input bit [31:0] a2,
                         input bit [3:0] l0, input bit [3:0] l1, input bit [3:0] l2,
                         input int nb, input int rst_at);
        bit [31:0] addr [NM];
        bit [3:0]  len  [NM];
        int m, slv, ln, g;
        addr = '{a0, a1, a2};
        len  = '{l0, l1, l2};
        ARVALID = av; ARADDR = {a2, a1, a0}; ARLEN = {l2, l1, l0}; wr_block = wb;
        ARREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
        m = pick(av & ~wb);
        step();
        if (m < 0) begin
            check({tag, ".nogrant"}, 32'(grant_valid), 32'd0);
            ARVALID = '0; wr_block = '0;
            return;
        end
        slv = decode(addr[m]);
        ln  = int'(len[m]);
        check({tag, ".gv"},  32'(grant_valid), 32'd1);
        check({tag, ".arp"}, 32'(ar_phase),    32'd1);
        check({tag, ".mst"}, 32'(grant_mst),   32'(m));
        check({tag, ".slv"}, 32'(grant_slv),   32'(slv));
        check({tag, ".dec"}, 32'(decerr),      32'(slv == NS));
        // Disturb everything the grant must ignore, including the owner's wr_block.
        ARVALID  = NM'($urandom) | NM'(1 << m);
        wr_block = NM'($urandom) | NM'(1 << m);
        for (int i = 0; i < NM; i++)
            if (i != m) begin
                ARADDR[i*AW +: AW] = $urandom;
                ARLEN[i*LW +: LW]  = LW'($urandom);
            end
        g = $urandom_range(0, 2);
        repeat (g) begin
            step();
            check({tag, ".arwait"}, 32'(ar_phase), 32'd1);
        end
        ARREADY = 1;
        step();
        ARREADY = 0;
        check({tag, ".ardone"}, 32'(ar_phase), 32'd0);
        for (int b = 1; b <= nb; b++) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                if ($urandom_range(0, 1) == 1) begin RVALID = 1; RREADY = 0; end
                else begin RVALID = 0; RREADY = 1; end
                RLAST = 1'($urandom_range(0, 1));
                step();
                check({tag, ".stall.lerr"}, 32'(len_err),     32'd0);
                check({tag, ".stall.gv"},   32'(grant_valid), 32'd1);
            end
            RVALID = 1; RREADY = 1; RLAST = (b == nb);
            step();
            RVALID = 0; RREADY = 0; RLAST = 0;
            check({tag, ".lerr"}, 32'(len_err),
                  32'((b == nb) ? (b - 1 != ln) : (b - 1 == ln)));
            check({tag, ".beat.gv"}, 32'(grant_valid), 32'(b != nb));
            if (b != nb) begin
                check({tag, ".beat.mst"}, 32'(grant_mst), 32'(m));
                check({tag, ".beat.slv"}, 32'(grant_slv), 32'(slv));
                check({tag, ".beat.dec"}, 32'(decerr),    32'(slv == NS));
            end else begin
                check({tag, ".end.dec"}, 32'(decerr), 32'd0);
            end
            if (b == rst_at) begin
                ARESETn = 0;
                step();
                check_reset({tag, ".midrst"});
                ARESETn = 1; ptr = 0; ARVALID = '0; wr_block = '0;
                return;
            end
        end
        ptr = (m + 1) % NM;
        ARVALID = '0; wr_block = '0;
    endtask

    function automatic bit [31:0] rand_addr();
        int k = $urandom_range(0, 9);
        if (k < NS) return map_base[k] | ($urandom & ~map_mask[k]);
        if (k == NS) return 32'h3000_0000 | ($urandom & 32'h0000_FFFF);
        return $urandom;
    endfunction

    initial begin
        reset_dut();
        step();
        check_reset("rst.idle");

        // Basic 4-beat burst from M1 to DM.
        burst("basic", 3'b010, 3'b000, 0, 32'h0002_0040, 0, 0, 3, 0, 4, 0);

        // M0 and M2 requesting back to back from a fresh pointer.
        reset_dut();
        for (int i = 0; i < 3; i++)
            burst("rr", 3'b101, 3'b000, 32'h0001_0000, 0, 32'h1000_0100, 1, 0, 2, 2, 0);

        // Decode: DRAM wide window and an unmapped address.
        burst("dram",   3'b001, 3'b000, 32'h2040_0000, 0, 0, 2, 0, 0, 3, 0);
        burst("decerr", 3'b001, 3'b000, 32'h3000_0000, 0, 0, 2, 0, 0, 3, 0);

        // Write-side blocking at grant time; raised mid-burst inside burst().
        burst("wrblk", 3'b011, 3'b001, 32'h0000_0010, 32'h0010_0020, 0, 1, 2, 0, 3, 0);
        burst("allblk", 3'b011, 3'b011, 0, 0, 0, 0, 0, 0, 1, 0);

        // ARLEN=1 but RLAST only on the third beat.
        burst("lenerr", 3'b100, 3'b000, 0, 0, 32'h0003_0008, 0, 0, 1, 3, 0);
        // Single-beat burst and one that ends early.
        burst("single", 3'b001, 3'b000, 32'h1001_0004, 0, 0, 0, 0, 0, 1, 0);
        burst("short",  3'b010, 3'b000, 0, 32'h0000_0004, 0, 0, 3, 0, 2, 0);

        // Reset in DATA, then a fresh request.
        burst("rstdata", 3'b110, 3'b000, 0, 32'h0001_0000, 32'h0002_0000, 0, 3, 3, 4, 2);
        burst("postrst", 3'b011, 3'b000, 32'h0000_0100, 32'h2000_0000, 0, 2, 0, 0, 3, 0);

        for (int t = 0; t < 40; t++) begin
            bit [NM-1:0] av, wb;
            bit [3:0] l0, l1, l2;
            int nb;
            av = NM'($urandom_range(1, 7));
            wb = ($urandom_range(0, 2) == 0) ? NM'($urandom) : NM'(0);
            l0 = 4'($urandom_range(0, 3));
            l1 = 4'($urandom_range(0, 3));
            l2 = 4'($urandom_range(0, 3));
            nb = 0;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 5);
            else begin
                int m = pick(av & ~wb);
                nb = (m == 0) ? int'(l0) + 1 : (m == 1) ? int'(l1) + 1 : int'(l2) + 1;
            end
            burst("rand", av, wb, rand_addr(), rand_addr(), rand_addr(), l0, l1, l2, nb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
